// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable clock divider and the board top.
package clk_div_pkg;

    // Output shape selector for clk_out.
    typedef enum logic {
        DIV_SQUARE = 1'b0,
        DIV_PULSE  = 1'b1
    } div_mode_e;

    // Defaults: 50 MHz system clock divided down to 1 Hz.
    localparam int unsigned CLK_DIV_WIDTH   = 26;
    localparam int unsigned CLK_DIV_DEFAULT = 50_000_000;

endpackage : clk_div_pkg

// File: rtl/div_reload_ctrl.sv
// Pending-divisor holder: captures div_in on div_load and releases it to the
// active divisor only at a period boundary, so the output never glitches.
module div_reload_ctrl
    import clk_div_pkg::*;
#(
    parameter int unsigned WIDTH = CLK_DIV_WIDTH
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             div_load,
    input  logic [WIDTH-1:0] div_in,
    input  logic             boundary,
    output logic [WIDTH-1:0] pend_div,
    output logic             pend_valid,
    output logic             apply
);

    // A pending value is handed over on any boundary edge.
    always_comb begin
        apply = pend_valid && boundary;
    end

    // Capture new loads; a load on an apply edge re-arms with the new value
    // while the top takes the old one, so the last load always wins.
    always_ff @(posedge clock) begin
        if (rst) begin
            pend_div   <= '0;
            pend_valid <= 1'b0;
        end else if (div_load) begin
            pend_div   <= div_in;
            pend_valid <= 1'b1;
        end else if (apply) begin
            pend_valid <= 1'b0;
        end
    end

endmodule : div_reload_ctrl

// File: rtl/prog_clk_divider.sv
// Fully synchronous programmable divider: produces a one-cycle tick per period
// and a registered square or pulse clk_out from a run-time divisor.
module prog_clk_divider
    import clk_div_pkg::*;
#(
    parameter int unsigned WIDTH       = CLK_DIV_WIDTH,
    parameter int unsigned DEFAULT_DIV = CLK_DIV_DEFAULT
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_load,
    input  logic             sync,
    output logic             clk_out,
    output logic             tick,
    output logic             div_pending
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] div_act;
    logic [WIDTH-1:0] pend_div;
    logic [WIDTH-1:0] div_next;
    logic             pend_valid;
    logic             apply;
    logic             idle;
    logic             last;
    logic             boundary;
    div_mode_e        mode_sel;

    // Period bookkeeping derived from the current counter and divisor.
    always_comb begin
        mode_sel = div_mode_e'(mode);
        idle     = (div_act == '0);
        // >= keeps the counter recoverable if a smaller divisor was applied
        // while paused with cnt beyond its new range.
        last     = !idle && (cnt >= div_act - ONE);
        boundary = !en || idle || sync || last;
        div_next = apply ? pend_div : div_act;
    end

    div_reload_ctrl #(
        .WIDTH(WIDTH)
    ) u_reload (
        .clock      (clock),
        .rst        (rst),
        .div_load   (div_load),
        .div_in     (div_in),
        .boundary   (boundary),
        .pend_div   (pend_div),
        .pend_valid (pend_valid),
        .apply      (apply)
    );

    assign div_pending = pend_valid;

    // Counter, active divisor and registered outputs.
    always_ff @(posedge clock) begin
        if (rst) begin
            cnt     <= '0;
            div_act <= WIDTH'(DEFAULT_DIV);
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            if (apply) begin
                div_act <= pend_div;
            end
            if (!en) begin
                tick <= 1'b0;
            end else if (sync) begin
                cnt     <= '0;
                tick    <= 1'b0;
                clk_out <= (mode_sel == DIV_SQUARE) && (div_next == ONE);
            end else if (idle) begin
                cnt     <= '0;
                tick    <= 1'b0;
                clk_out <= 1'b0;
            end else begin
                cnt     <= last ? '0 : cnt + ONE;
                tick    <= last;
                clk_out <= (mode_sel == DIV_PULSE) ? last : (cnt >= (div_act >> 1));
            end
        end
    end

endmodule : prog_clk_divider

// File: tb/tb_prog_clk_divider.sv
// Self-checking bench for prog_clk_divider: table-driven reload sequence plus
// hand-written corner-case sequences, all checked through a scoreboard queue.
module tb_prog_clk_divider;
    import clk_div_pkg::*;

    localparam int unsigned W = CLK_DIV_WIDTH;

    logic         clock = 1'b0;
    logic         rst, en, mode, div_load, sync;
    logic [W-1:0] div_in;
    logic         clk_out, tick, div_pending;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    typedef struct {
        logic         r, e, m, s, l;
        logic [W-1:0] dv;
        logic         et, ec, ep;
    } vec_t;

    typedef struct {
        logic  et, ec, ep, cc;
        string nm;
    } exp_t;

    exp_t exp_q[$];
    vec_t tbl[14];

    prog_clk_divider #(
        .WIDTH       (W),
        .DEFAULT_DIV (CLK_DIV_DEFAULT)
    ) dut (
        .clock       (clock),
        .rst         (rst),
        .en          (en),
        .mode        (mode),
        .div_in      (div_in),
        .div_load    (div_load),
        .sync        (sync),
        .clk_out     (clk_out),
        .tick        (tick),
        .div_pending (div_pending)
    );

    always #5 clock = ~clock;

    task automatic cmp(input string nm, input string sig, input logic act, input logic req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s: got %0b expected %0b at %0t", nm, sig, act, req, $time);
        end
    endtask

    // Drive one cycle, push expectation, clock, then pop and compare.
    task automatic step(input logic r, e, m, s, l, input logic [W-1:0] dv,
                        input logic et, ec, ep, cc, input string nm);
        exp_t x;
        rst = r; en = e; mode = m; sync = s; div_load = l; div_in = dv;
        exp_q.push_back('{et: et, ec: ec, ep: ep, cc: cc, nm: nm});
        @(posedge clock);
        #1;
        x = exp_q.pop_front();
        cmp(x.nm, "tick", tick, x.et);
        if (x.cc) cmp(x.nm, "clk_out", clk_out, x.ec);
        cmp(x.nm, "div_pending", div_pending, x.ep);
    endtask

    initial begin
        // D=6 running, load 3 at cnt=2: r, e, m, s, l, div, tick, clk, pend
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, W'(6), 1'b0, 1'b1, 1'b1};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, W'(0), 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, W'(0), 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, W'(0), 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, W'(3), 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, W'(0), 1'b0, 1'b1, 1'b1};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, W'(0), 1'b0, 1'b1, 1'b1};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, W'(0), 1'b1, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, W'(0), 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, W'(0), 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, W'(0), 1'b1, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, W'(0), 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, W'(0), 1'b0, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, W'(0), 1'b1, 1'b1, 1'b0};

        rst = 1'b1; en = 1'b0; mode = 1'b0; sync = 1'b0; div_load = 1'b0; div_in = '0;
        @(negedge clock);

        // Reset defaults, then D=4 square
        step(1, 0, 0, 0, 0, W'(0), 0, 0, 0, 1, "reset");
        step(0, 0, 0, 0, 1, W'(4), 0, 0, 1, 1, "load4");
        step(0, 0, 0, 0, 0, W'(0), 0, 0, 0, 1, "apply4");
        for (int k = 1; k <= 12; k++)
            step(0, 1, 0, 0, 0, W'(0), (k % 4) == 0, ((k - 1) % 4) >= 2, 0, 1, "sq4");

        // Reload D=6 -> 3 from the table
        for (int i = 0; i < 14; i++)
            step(tbl[i].r, tbl[i].e, tbl[i].m, tbl[i].s, tbl[i].l, tbl[i].dv,
                 tbl[i].et, tbl[i].ec, tbl[i].ep, 1, "reload");

        // D=0 while paused, then D=1
        step(0, 0, 0, 0, 1, W'(0), 0, 1, 1, 1, "load0");
        step(0, 0, 0, 0, 0, W'(0), 0, 1, 0, 1, "apply0");
        for (int k = 0; k < 20; k++)
            step(0, 1, 0, 0, 0, W'(0), 0, 0, 0, 1, "idle0");
        step(0, 1, 0, 0, 1, W'(1), 0, 0, 1, 1, "load1");
        step(0, 1, 0, 0, 0, W'(0), 0, 0, 0, 1, "apply1");
        for (int k = 0; k < 10; k++)
            step(0, 1, 0, 0, 0, W'(0), 1, 1, 0, 1, "d1_sq");
        for (int k = 0; k < 4; k++)
            step(0, 1, 1, 0, 0, W'(0), 1, 1, 0, 1, "d1_pulse");

        // D=5 pulse mode with a 7-cycle pause mid-period
        step(0, 1, 1, 0, 1, W'(5), 1, 1, 1, 1, "load5");
        step(0, 1, 1, 0, 0, W'(0), 1, 1, 0, 1, "apply5");
        for (int n = 1; n <= 3; n++)
            step(0, 1, 1, 0, 0, W'(0), (n % 5) == 0, (n % 5) == 0, 0, 1, "p5_pre");
        for (int k = 0; k < 7; k++)
            step(0, 0, 1, 0, 0, W'(0), 0, 0, 0, 1, "p5_pause");
        for (int n = 4; n <= 15; n++)
            step(0, 1, 1, 0, 0, W'(0), (n % 5) == 0, (n % 5) == 0, 0, 1, "p5_post");

        // D=8, two loads (last wins), sync at cnt=5 applies D=2
        step(0, 0, 0, 0, 1, W'(8), 0, 1, 1, 1, "load8");
        step(0, 0, 0, 0, 0, W'(0), 0, 1, 0, 1, "apply8");
        for (int n = 1; n <= 3; n++)
            step(0, 1, 0, 0, 0, W'(0), 0, 0, 0, 1, "d8");
        step(0, 1, 0, 0, 1, W'(3), 0, 0, 1, 1, "d8_load3");
        step(0, 1, 0, 0, 1, W'(2), 0, 1, 1, 1, "d8_load2");
        step(0, 1, 0, 1, 0, W'(0), 0, 0, 0, 1, "sync");
        for (int j = 1; j <= 8; j++)
            step(0, 1, 0, 0, 0, W'(0), (j % 2) == 0, (j % 2) == 0, 0, 1, "d2");

        // D=7 with a load pending, reset mid-period
        step(0, 0, 0, 0, 1, W'(7), 0, 1, 1, 1, "load7");
        step(0, 0, 0, 0, 0, W'(0), 0, 1, 0, 1, "apply7");
        for (int n = 1; n <= 3; n++)
            step(0, 1, 0, 0, 0, W'(0), 0, 0, 0, 1, "d7");
        step(0, 1, 0, 0, 1, W'(4), 0, 1, 1, 1, "d7_load4");
        step(1, 1, 0, 1, 1, W'(9), 0, 0, 0, 1, "mid_rst");
        for (int k = 0; k < 10; k++)
            step(0, 1, 0, 0, 0, W'(0), 0, 0, 0, 1, "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time limit so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule : tb_prog_clk_divider

// File: doc/prog_clk_divider.md
# prog_clk_divider

Parametrised, fully synchronous clock divider and tick generator for low-rate logic such as display refresh, LED blink, debouncers and slow FSMs. Single clock domain; no ripple stages and no derived clocks. Produces a clock-enable tick and a divided square or pulse output from a run-time divisor. The divisor is reloaded glitch-free at period boundaries.

## Interface
Parameters:
- WIDTH, 26, width of divisor and counter.
- DEFAULT_DIV, 50_000_000, divisor applied at reset; must fit in WIDTH bits.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  count enable; low freezes the divider.
- mode  in  1  0 = square output, 1 = pulse output (clk_out mirrors tick).
- div_in  in  WIDTH  new divisor D, unsigned.
- div_load  in  1  one-cycle strobe; captures div_in into pending register.
- sync  in  1  one-cycle strobe; restarts current period.
- clk_out  out  1  divided output, registered.
- tick  out  1  one-cycle enable pulse per period, registered.
- div_pending  out  1  high while a loaded divisor awaits its period boundary.

## Operation
- Active divisor D, counter cnt in 0..D-1, pending register P with valid flag (div_pending).
- Count (en=1, D>=1): cnt <= (cnt==D-1) ? 0 : cnt+1.
- tick <= en && D>=1 && (cnt==D-1).
- Square mode: clk_out <= (cnt >= D>>1). Per period: low floor(D/2) cycles, then high ceil(D/2) cycles.
- Pulse mode: clk_out <= same value as tick.
- en=0: cnt, D and clk_out hold; tick <= 0.
- D=0: divider idle. cnt held at 0, tick 0, clk_out 0.
- D=1: tick every cycle; clk_out constant 1 in both modes.
- Reload: div_load sets P <= div_in and div_pending <= 1.
  - P is applied (D <= P, div_pending <= 0) on the edge where cnt wraps to 0.
  - Also applied immediately on the next edge if en=0 or D=0.
  - Several loads before a boundary: the last one wins.
  - Load on the same edge as a wrap: the new value goes to P and is applied at the following boundary. The wrap uses the old P if one was pending.
- sync: cnt <= 0; any pending P is applied on that edge; tick <= 0 for that edge. sync has priority over counting. Ignored while en=0.
- mode may change at any time; it takes effect on the next edge with no counter disturbance.
- Reset: cnt=0, D=DEFAULT_DIV, P cleared, div_pending=0, clk_out=0, tick=0. rst overrides all other inputs, including mid-period.

## Timing
- Reset released with en=1: edge k counts as edge 1.
- First tick is high after edge D, then after edges 2D, 3D, …
- Square output, D=4: clk_out is 0 after edges 1–2, 1 after edges 3–4, and repeats with period 4.
- Square output, D=5: low 2 cycles, high 3 cycles.
- Output latency: one register stage from cnt to tick and clk_out.
- Reload latency: at most D_old cycles from div_load to the new period start. div_pending falls on the same edge the new period starts.
- No combinational path from any input to any output.

## Structure
- Shared package clk_div_pkg:
  - typedef for the mode encoding (DIV_SQUARE=0, DIV_PULSE=1).
  - Default WIDTH and DEFAULT_DIV constants, reused by the board top.
- One natural sub-module, div_reload_ctrl. It holds P and div_pending and decides the apply strobe. Counter and output registers stay in the top.
- Estimated RTL size: 150–250 lines.

## Test plan
- Reset defaults, then D=4 via load, en=1, mode=0: clk_out pattern 0,0,1,1 repeating; tick after edges 4, 8, 12; div_pending clears on the first wrap.
- D=6 running, div_load of 3 at cnt=2: old period completes, tick at cnt=5 wrap; following ticks every 3 cycles; div_pending high exactly for the intervening cycles.
- D=0 loaded while en=0: applied next edge; tick and clk_out stay 0 for 20 cycles. Then load D=1: tick high every cycle, clk_out=1.
- D=5, mode=1, en dropped for 7 cycles mid-period: no tick during the pause; after resuming, tick spacing counts only enabled cycles (5 total across the pause).
- D=8, sync asserted at cnt=5 with a pending load of 2: cnt restarts, D=2 applied that edge, ticks every 2 cycles afterwards.
- rst asserted mid-period with D=7 and a load pending: next cycle cnt=0, D=DEFAULT_DIV, div_pending=0, clk_out=0, tick=0.
